m2v_isdq: RTL and testbench

MPEG-2 video inverse-scan and inverse-quantisation stage. Sits between the run/level (VLD) decoder and the IDCT.
- Takes run/level pairs per 8x8 block plus per-block side info.
- Applies zigzag inverse scan, MPEG-2 dequantisation, saturation and mismatch control.
- Delivers 64 coefficients per block in raster order through a pull interface.
- Also holds the intra and non-intra quantiser matrices.

---
 rtl/m2v_isdq.sv | 254 +++++++++++++++++++++++++
 tb/tb_m2v_isdq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m2v_isdq.sv
// m2v_isdq: MPEG-2 inverse scan and inverse quantisation stage.
// Run/level pairs in, 64 raster-order sign-magnitude coefficients out per block.
// Two ping-pong block banks, plus the intra and non-intra quantiser matrices.
// Optional: define M2V_ISDQ_MISMATCH_EN to enable mismatch control on coefficient 63.
module m2v_isdq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        softreset,
    output logic        ready_isdq,
    input  logic        block_start,
    input  logic        block_end,
    input  logic        s0_enable,
    input  logic        s1_coded,
    input  logic        s1_mb_intra,
    input  logic [4:0]  s1_mb_qscode,
    input  logic        sa_qstype,
    input  logic [1:0]  sa_dcprec,
    input  logic [5:0]  run,
    input  logic        level_sign,
    input  logic [10:0] level_data,
    input  logic        rl_valid,
    input  logic        qm_valid,
    input  logic        qm_custom,
    input  logic        qm_intra,
    input  logic [7:0]  qm_value,
    output logic        coef_sign,
    output logic [11:0] coef_data,
    input  logic        coef_next
);
    // Zigzag scan position -> raster index.
    localparam logic [5:0] ZIGZAG [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
    // Default intra matrix, raster order.
    localparam logic [7:0] DEF_INTRA [64] = '{
         8, 16, 19, 22, 26, 27, 29, 34, 16, 16, 22, 24, 27, 29, 34, 37,
        19, 22, 26, 27, 29, 34, 34, 38, 22, 22, 26, 27, 29, 34, 37, 40,
        22, 26, 27, 29, 32, 35, 40, 48, 26, 27, 29, 32, 35, 40, 48, 58,
        26, 27, 29, 34, 38, 46, 56, 69, 27, 29, 35, 38, 46, 56, 69, 83};
    localparam logic [7:0] DEF_NON [64] = '{default: 8'd16};
    // Non-linear quantiser scale, indexed by quantiser_scale_code (entry 0 unused).
    localparam logic [6:0] NL_QS [32] = '{
          0,   1,   2,   3,   4,   5,   6,   7,   8,  10,  12,  14,  16,  18,  20,  22,
         24,  28,  32,  36,  40,  44,  48,  52,  56,  64,  72,  80,  88,  96, 104, 112};

    typedef logic [12:0] entry_t;   // {sign, 12-bit magnitude}

    // Block banks: index by bank select, then raster position.
    entry_t      bank_q [2][64], bank_d [2][64];
    logic [1:0]  bank_par_q, bank_par_d, bank_coded_q, bank_coded_d;
    // Quantiser matrices: [0] non-intra, [1] intra; raster order.
    logic [7:0]  qm_q [2][64], qm_d [2][64];
    logic [5:0]  qm_cnt_q [2], qm_cnt_d [2];
    // Open-block context.
    logic        open_q, open_d, end1_q, end1_d, wr_sel_q, wr_sel_d;
    logic        coded_q, coded_d, intra_q, intra_d, qstype_q, qstype_d;
    logic [4:0]  qscode_q, qscode_d;
    logic [1:0]  dcprec_q, dcprec_d;
    logic [6:0]  pos_q, pos_d;
    // Dequantisation stage register.
    logic        s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_dc_q, s1_dc_d;
    logic [5:0]  s1_raster_q, s1_raster_d;
    logic [10:0] s1_lvl_q, s1_lvl_d;
    logic [7:0]  s1_w_q, s1_w_d;
    // Readout FIFO state.
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_sel_q, rd_sel_d;
    logic [5:0]  idx_q, idx_d;

    logic        start_take, end_take, rl_take, pop, free_bank;
    logic [6:0]  p_eff, qs;
    logic [11:0] two_l_k, sat_mag;
    logic [26:0] prod;
    logic [13:0] dc_mag;
    logic [21:0] raw_mag;
    entry_t      rd_entry;

    assign ready_isdq = !open_q && !end1_q && (cnt_q != 2'd2);

    // Accept block commands, advance the scan position, fill the dequantisation stage.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first, otherwise a latch is inferred.
        start_take  = block_start && s0_enable && ready_isdq;
        end_take    = block_end && open_q;
        p_eff       = pos_q + {1'b0, run};
        rl_take     = rl_valid && open_q && coded_q && !p_eff[6];
        open_d      = open_q;
        end1_d      = end_take;
        wr_sel_d    = wr_sel_q;
        coded_d     = coded_q;
        intra_d     = intra_q;
        qstype_d    = qstype_q;
        qscode_d    = qscode_q;
        dcprec_d    = dcprec_q;
        pos_d       = pos_q;
        s1_valid_d  = rl_take;
        s1_raster_d = ZIGZAG[p_eff[5:0]];
        s1_w_d      = qm_q[intra_q][ZIGZAG[p_eff[5:0]]];
        s1_lvl_d    = level_data;
        s1_sign_d   = level_sign;
        s1_dc_d     = intra_q && (p_eff == 7'd0);
        if (rl_valid && open_q && coded_q)
            pos_d = p_eff[6] ? 7'd64 : p_eff + 7'd1;
        if (start_take) begin
            open_d   = 1'b1;
            wr_sel_d = rd_sel_q ^ cnt_q[0];   // next bank after the readable ones
            coded_d  = s1_coded;
            intra_d  = s1_mb_intra;
            qstype_d = sa_qstype;
            qscode_d = s1_mb_qscode;
            dcprec_d = sa_dcprec;
            pos_d    = 7'd0;
        end
        if (end_take)
            open_d = 1'b0;
        if (softreset) begin
            open_d     = 1'b0;
            end1_d     = 1'b0;
            pos_d      = 7'd0;
            s1_valid_d = 1'b0;
        end
    end

    // Dequantise, saturate and write the staged coefficient; clear the bank at block start.
    always_comb begin
        qs      = qstype_q ? NL_QS[qscode_q] : {1'b0, qscode_q, 1'b0};
        two_l_k = {s1_lvl_q, 1'b0} + {11'd0, ~intra_q};
        prod    = {15'd0, two_l_k} * {19'd0, s1_w_q} * {20'd0, qs};
        dc_mag  = {3'd0, s1_lvl_q} << (2'd3 - dcprec_q);
        raw_mag = s1_dc_q ? {8'd0, dc_mag} : 22'(prod >> 5);
        if (s1_sign_q)
            sat_mag = (raw_mag > 22'd2048) ? 12'd2048 : raw_mag[11:0];
        else
            sat_mag = (raw_mag > 22'd2047) ? 12'd2047 : raw_mag[11:0];
        bank_d       = bank_q;
        bank_par_d   = bank_par_q;
        bank_coded_d = bank_coded_q;
        if (start_take) begin
            for (int i = 0; i < 64; i++)
                bank_d[wr_sel_d][i] = '0;
            bank_par_d[wr_sel_d]   = 1'b0;
            bank_coded_d[wr_sel_d] = s1_coded;
        end
        if (s1_valid_q) begin
            bank_d[wr_sel_q][s1_raster_q] = {s1_sign_q, sat_mag};
            bank_par_d[wr_sel_q]          = bank_par_q[wr_sel_q] ^ sat_mag[0];
        end
    end

    // Readout FIFO: commit drained banks, pop coefficients, free a bank after entry 63.
    always_comb begin
        pop       = coef_next && (cnt_q != 2'd0);
        free_bank = pop && (idx_q == 6'd63);
        idx_d     = pop ? idx_q + 6'd1 : idx_q;
        rd_sel_d  = free_bank ? ~rd_sel_q : rd_sel_q;
        cnt_d     = cnt_q + {1'b0, end1_q} - {1'b0, free_bank};
        if (softreset) begin
            idx_d    = 6'd0;
            rd_sel_d = 1'b0;
            cnt_d    = 2'd0;
        end
    end

    // Quantiser matrix commands: revert to default or load the next zigzag entry.
    always_comb begin
        qm_d     = qm_q;
        qm_cnt_d = qm_cnt_q;
        if (qm_valid) begin
            if (!qm_custom) begin
                qm_cnt_d[qm_intra] = 6'd0;
                if (qm_intra) qm_d[1] = DEF_INTRA;
                else          qm_d[0] = DEF_NON;
            end else begin
                qm_d[qm_intra][ZIGZAG[qm_cnt_q[qm_intra]]] = qm_value;
                qm_cnt_d[qm_intra] = qm_cnt_q[qm_intra] + 6'd1;
            end
        end
        if (softreset) begin
            qm_d[0]  = DEF_NON;
            qm_d[1]  = DEF_INTRA;
            qm_cnt_d = '{6'd0, 6'd0};
        end
    end

    // Present the current coefficient of the oldest readable bank.
    always_comb begin
        rd_entry  = (cnt_q != 2'd0) ? bank_q[rd_sel_q][idx_q] : '0;
        coef_sign = rd_entry[12];
        coef_data = rd_entry[11:0];
`ifdef M2V_ISDQ_MISMATCH_EN
        if ((cnt_q != 2'd0) && (idx_q == 6'd63) && bank_coded_q[rd_sel_q] && !bank_par_q[rd_sel_q])
            coef_data[0] = ~coef_data[0];
`endif
    end

    // Control, matrix and pipeline state with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            open_q      <= 1'b0;
            end1_q      <= 1'b0;
            wr_sel_q    <= 1'b0;
            coded_q     <= 1'b0;
            intra_q     <= 1'b0;
            qstype_q    <= 1'b0;
            qscode_q    <= 5'd0;
            dcprec_q    <= 2'd0;
            pos_q       <= 7'd0;
            s1_valid_q  <= 1'b0;
            s1_raster_q <= 6'd0;
            s1_lvl_q    <= 11'd0;
            s1_sign_q   <= 1'b0;
            s1_dc_q     <= 1'b0;
            s1_w_q      <= 8'd0;
            cnt_q       <= 2'd0;
            rd_sel_q    <= 1'b0;
            idx_q       <= 6'd0;
            qm_q[0]     <= DEF_NON;
            qm_q[1]     <= DEF_INTRA;
            qm_cnt_q    <= '{6'd0, 6'd0};
        end else begin
            open_q      <= open_d;
            end1_q      <= end1_d;
            wr_sel_q    <= wr_sel_d;
            coded_q     <= coded_d;
            intra_q     <= intra_d;
            qstype_q    <= qstype_d;
            qscode_q    <= qscode_d;
            dcprec_q    <= dcprec_d;
            pos_q       <= pos_d;
            s1_valid_q  <= s1_valid_d;
            s1_raster_q <= s1_raster_d;
            s1_lvl_q    <= s1_lvl_d;
            s1_sign_q   <= s1_sign_d;
            s1_dc_q     <= s1_dc_d;
            s1_w_q      <= s1_w_d;
            cnt_q       <= cnt_d;
            rd_sel_q    <= rd_sel_d;
            idx_q       <= idx_d;
            qm_q        <= qm_d;
            qm_cnt_q    <= qm_cnt_d;
        end
    end

    // Block bank storage.
    always_ff @(posedge clk) begin
        // NOTE: bank contents need no reset; a bank is cleared when a block opens and is unreadable until committed.
        bank_q       <= bank_d;
        bank_par_q   <= bank_par_d;
        bank_coded_q <= bank_coded_d;
    end
endmodule

// File: tb/tb_m2v_isdq.sv
// tb_m2v_isdq: directed bench for m2v_isdq with a block-level reference model.
// Each closed block is modelled as a 64-entry raster array pushed into a queue;
// one compare process checks the current output against the queue head every cycle.
module tb_m2v_isdq;
`ifdef M2V_ISDQ_MISMATCH_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif
    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
    localparam int DEF_I [64] = '{
         8, 16, 19, 22, 26, 27, 29, 34, 16, 16, 22, 24, 27, 29, 34, 37,
        19, 22, 26, 27, 29, 34, 34, 38, 22, 22, 26, 27, 29, 34, 37, 40,
        22, 26, 27, 29, 32, 35, 40, 48, 26, 27, 29, 32, 35, 40, 48, 58,
        26, 27, 29, 34, 38, 46, 56, 69, 27, 29, 35, 38, 46, 56, 69, 83};
    localparam int NLQ [32] = '{
          0,   1,   2,   3,   4,   5,   6,   7,   8,  10,  12,  14,  16,  18,  20,  22,
         24,  28,  32,  36,  40,  44,  48,  52,  56,  64,  72,  80,  88,  96, 104, 112};

    logic        clk = 1'b0, reset_n = 1'b0, softreset = 1'b0;
    logic        ready_isdq, block_start = 1'b0, block_end = 1'b0, s0_enable = 1'b1;
    logic        s1_coded = 1'b0, s1_mb_intra = 1'b0, sa_qstype = 1'b0;
    logic [4:0]  s1_mb_qscode = 5'd1;
    logic [1:0]  sa_dcprec = 2'd0;
    logic [5:0]  run = 6'd0;
    logic        level_sign = 1'b0, rl_valid = 1'b0;
    logic [10:0] level_data = 11'd0;
    logic        qm_valid = 1'b0, qm_custom = 1'b0, qm_intra = 1'b0;
    logic [7:0]  qm_value = 8'd0;
    logic        coef_sign, coef_next = 1'b0;
    logic [11:0] coef_data;

    m2v_isdq dut (
        .clk(clk), .reset_n(reset_n), .softreset(softreset), .ready_isdq(ready_isdq),
        .block_start(block_start), .block_end(block_end), .s0_enable(s0_enable),
        .s1_coded(s1_coded), .s1_mb_intra(s1_mb_intra), .s1_mb_qscode(s1_mb_qscode),
        .sa_qstype(sa_qstype), .sa_dcprec(sa_dcprec), .run(run), .level_sign(level_sign),
        .level_data(level_data), .rl_valid(rl_valid), .qm_valid(qm_valid),
        .qm_custom(qm_custom), .qm_intra(qm_intra), .qm_value(qm_value),
        .coef_sign(coef_sign), .coef_data(coef_data), .coef_next(coef_next));

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state. Entries are encoded as sign*4096 + magnitude.
    int exp_q[$];
    int midx = 0;
    bit settling = 1'b0;
    int mat_i [64], mat_n [64];
    int cnt_i, cnt_n;
    int cur [64];
    int cur_p, cur_qs, cur_dcprec;
    bit cur_par, cur_intra, cur_coded;

    task automatic model_reset();
        exp_q.delete();
        midx = 0;
        for (int i = 0; i < 64; i++) begin
            mat_i[i] = DEF_I[i];
            mat_n[i] = 16;
        end
        cnt_i = 0;
        cnt_n = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input bit coded, input bit intra, input int qscode,
                               input bit qstype, input int dcprec);
        block_start  = 1'b1;
        s0_enable    = 1'b1;
        s1_coded     = coded;
        s1_mb_intra  = intra;
        s1_mb_qscode = 5'(qscode);
        sa_qstype    = qstype;
        sa_dcprec    = 2'(dcprec);
        tick();
        block_start = 1'b0;
        for (int i = 0; i < 64; i++) cur[i] = 0;
        cur_p      = 0;
        cur_par    = 1'b0;
        cur_intra  = intra;
        cur_coded  = coded;
        cur_qs     = qstype ? NLQ[qscode] : 2 * qscode;
        cur_dcprec = dcprec;
    endtask

    task automatic send_pair(input int r, input bit neg, input int lvl);
        int mag, rast;
        run        = 6'(r);
        level_sign = neg;
        level_data = 11'(lvl);
        rl_valid   = 1'b1;
        tick();
        rl_valid = 1'b0;
        if (cur_coded) begin
            cur_p += r;
            if (cur_p <= 63) begin
                rast = ZZ[cur_p];
                if (cur_intra && cur_p == 0)
                    mag = lvl * (8 >> cur_dcprec);
                else
                    mag = ((2 * lvl + (cur_intra ? 0 : 1)) * (cur_intra ? mat_i[rast] : mat_n[rast]) * cur_qs) / 32;
                if (neg && mag > 2048) mag = 2048;
                if (!neg && mag > 2047) mag = 2047;
                cur[rast] = (neg ? 4096 : 0) + mag;
                cur_par ^= mag[0];
                cur_p++;
            end
        end
    endtask

    task automatic end_block();
        block_end = 1'b1;
        tick();
        block_end = 1'b0;
        settling  = 1'b1;
        repeat (4) tick();
        if (MM && cur_coded && !cur_par) cur[63] ^= 1;
        for (int i = 0; i < 64; i++) exp_q.push_back(cur[i]);
        settling = 1'b0;
    endtask

    task automatic pop_n(input int n);
        coef_next = 1'b1;
        repeat (n) tick();
        coef_next = 1'b0;
    endtask

    task automatic qm_cmd(input bit custom, input bit intra, input int val);
        qm_valid  = 1'b1;
        qm_custom = custom;
        qm_intra  = intra;
        qm_value  = 8'(val);
        tick();
        qm_valid = 1'b0;
        if (!custom) begin
            for (int i = 0; i < 64; i++) begin
                if (intra) mat_i[i] = DEF_I[i];
                else       mat_n[i] = 16;
            end
            if (intra) cnt_i = 0; else cnt_n = 0;
        end else if (intra) begin
            mat_i[ZZ[cnt_i]] = val;
            cnt_i = (cnt_i + 1) % 64;
        end else begin
            mat_n[ZZ[cnt_n]] = val;
            cnt_n = (cnt_n + 1) % 64;
        end
    endtask

    // Model pop: follows the consumer handshake on each rising edge.
    always @(posedge clk) begin
        if (reset_n && !softreset && coef_next && exp_q.size() > 0) begin
            if (midx == 63) begin
                repeat (64) void'(exp_q.pop_front());
                midx = 0;
            end else begin
                midx = midx + 1;
            end
        end
    end

    // Compare process: outputs against the model head on every falling edge.
    always @(negedge clk) begin
        int e;
        if (reset_n && !softreset && !(settling && exp_q.size() == 0)) begin
            e = (exp_q.size() > 0) ? exp_q[midx] : 0;
            check($sformatf("coef[%0d]", midx), int'({coef_sign, coef_data}), e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        tick();
        check("reset_ready", int'(ready_isdq), 1);
        check("reset_coef_data", int'(coef_data), 0);
        check("reset_coef_sign", int'(coef_sign), 0);
        reset_n = 1'b1;
        tick();

        // block_start with processing disabled is ignored
        block_start = 1'b1;
        s0_enable   = 1'b0;
        tick();
        block_start = 1'b0;
        s0_enable   = 1'b1;
        check("disabled_start_ready", int'(ready_isdq), 1);

        // Non-intra, linear qscale 8, default W: (7*16*16)>>5 = 56
        start_block(1, 0, 8, 0, 0);
        send_pair(0, 0, 3);
        end_block();
        check("t1_raster0", int'(coef_data), 56);
        pop_n(64);

        // Intra DC at precision 0 and one AC term
        start_block(1, 1, 4, 0, 0);
        send_pair(0, 0, 100);
        send_pair(0, 0, 2);
        end_block();
        check("t2_dc", int'(coef_data), 800);
        pop_n(1);
        check("t2_ac", int'(coef_data), 16);
        pop_n(62);
        check("t2_raster63", int'(coef_data), MM ? 1 : 0);
        pop_n(1);

        // Saturation, negative then positive, at raster zigzag[5] = 2
        start_block(1, 0, 31, 0, 0);
        send_pair(5, 1, 2047);
        end_block();
        pop_n(2);
        check("t3_neg_sign", int'(coef_sign), 1);
        check("t3_neg_data", int'(coef_data), 2048);
        pop_n(62);
        start_block(1, 0, 31, 0, 0);
        send_pair(5, 0, 2047);
        end_block();
        pop_n(2);
        check("t3_pos_data", int'(coef_data), 2047);
        pop_n(62);

        // Non-linear qscale 112
        start_block(1, 0, 31, 1, 0);
        send_pair(0, 0, 1);
        end_block();
        check("t4_nonlinear", int'(coef_data), 168);
        pop_n(64);

        // Custom non-intra matrix of all 32, then revert to default
        for (int i = 0; i < 64; i++) qm_cmd(1, 0, 32);
        start_block(1, 0, 1, 0, 0);
        send_pair(0, 0, 1);
        end_block();
        check("t5_custom", int'(coef_data), 6);
        pop_n(64);
        qm_cmd(0, 0, 0);
        start_block(1, 0, 1, 0, 0);
        send_pair(0, 0, 1);
        end_block();
        check("t5_default", int'(coef_data), 3);
        pop_n(64);

        // Intra, dcprec 2, back-to-back pairs with runs; the last two fall past 63
        start_block(1, 1, 10, 0, 2);
        send_pair(0, 1, 50);
        send_pair(10, 0, 5);
        send_pair(20, 1, 7);
        send_pair(40, 0, 3);
        send_pair(0, 0, 9);
        end_block();
        check("t6_dc", int'({coef_sign, coef_data}), 4096 + 100);
        pop_n(64);

        // Two blocks back to back, the second uncoded with a stray pair
        start_block(1, 0, 5, 0, 0);
        send_pair(0, 0, 4);
        send_pair(1, 1, 9);
        send_pair(60, 0, 1);
        end_block();
        start_block(0, 0, 5, 0, 0);
        check("t7_ready_open", int'(ready_isdq), 0);
        send_pair(0, 0, 7);
        end_block();
        check("t7_ready_full", int'(ready_isdq), 0);
        pop_n(64);
        check("t7_ready_one_free", int'(ready_isdq), 1);
        pop_n(64);

        // Asynchronous reset in the middle of readout
        start_block(1, 0, 8, 0, 0);
        send_pair(0, 0, 3);
        send_pair(9, 1, 20);
        end_block();
        pop_n(10);
        reset_n = 1'b0;
        model_reset();
        #2;
        check("t8_reset_data", int'(coef_data), 0);
        check("t8_reset_ready", int'(ready_isdq), 1);
        tick();
        reset_n = 1'b1;
        tick();

        // Synchronous soft reset in the middle of readout
        start_block(1, 0, 8, 0, 0);
        send_pair(0, 0, 3);
        end_block();
        pop_n(3);
        softreset = 1'b1;
        tick();
        softreset = 1'b0;
        model_reset();
        check("t9_soft_data", int'(coef_data), 0);
        check("t9_soft_ready", int'(ready_isdq), 1);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
